// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master engine FSM encoding.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_RSP
  } state_t;

endpackage

// File: rtl/axil_master_engine_if.sv
// AXI4-Lite bus bundle; master drives the address/data channels, slave the responses.
interface axil_master_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_W-1:0]     AWADDR;
  logic [2:0]            AWPROT;
  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_W-1:0]     WDATA;
  logic [DATA_W/8-1:0]   WSTRB;
  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_W-1:0]     ARADDR;
  logic [2:0]            ARPROT;
  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_W-1:0]     RDATA;
  logic [1:0]            RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, input AWREADY,
    output WVALID, WDATA, WSTRB, input WREADY,
    input BVALID, BRESP, output BREADY,
    output ARVALID, ARADDR, ARPROT, input ARREADY,
    input RVALID, RDATA, RRESP, output RREADY
  );

  modport slave (
    input AWVALID, AWADDR, AWPROT, output AWREADY,
    input WVALID, WDATA, WSTRB, output WREADY,
    output BVALID, BRESP, input BREADY,
    input ARVALID, ARADDR, ARPROT, output ARREADY,
    output RVALID, RDATA, RRESP, input RREADY
  );

endinterface

// File: rtl/axil_chan_hold.sv
// VALID/payload hold register: raised on load, held until its handshake, then dropped.
module axil_chan_hold #(
  parameter int W = 32
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic         load,
  input  logic         abort,
  input  logic         ready,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (abort || (valid && ready)) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_master_engine.sv
// Single-outstanding AXI4-Lite master: one command in, one response out.
// Optional watchdog abort enabled with `define AXIL_MASTER_TIMEOUT_EN.
module axil_master_engine
  import axil_pkg::*;
#(
  parameter int         ADDR_W      = 32,
  parameter int         DATA_W      = 32,
  parameter int         TIMEOUT_CYC = 256,
  parameter logic [2:0] PROT        = 3'b000
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  axil_master_engine_if.master axi
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state, state_next;
  logic                accept, busy, done_now, timeout_hit;
  logic                aw_valid, w_valid, ar_valid, aw_ok, w_ok;
  logic [ADDR_W-1:0]   aw_addr, ar_addr;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state == ST_WADDR) || (state == ST_WRESP) ||
                     (state == ST_RADDR) || (state == ST_RDATA);
  assign done_now  = ((state == ST_WRESP) && axi.BVALID) ||
                     ((state == ST_RDATA) && axi.RVALID);

  axil_chan_hold #(.W(ADDR_W)) u_aw (
    .ACLK(ACLK), .ARESETn(ARESETn), .load(accept && cmd_write), .abort(timeout_hit),
    .ready(axi.AWREADY), .din(cmd_addr), .valid(aw_valid), .dout(aw_addr)
  );

  axil_chan_hold #(.W(DATA_W + STRB_W)) u_w (
    .ACLK(ACLK), .ARESETn(ARESETn), .load(accept && cmd_write), .abort(timeout_hit),
    .ready(axi.WREADY), .din({cmd_wdata, cmd_wstrb}), .valid(w_valid),
    .dout({w_data, w_strb})
  );

  axil_chan_hold #(.W(ADDR_W)) u_ar (
    .ACLK(ACLK), .ARESETn(ARESETn), .load(accept && !cmd_write), .abort(timeout_hit),
    .ready(axi.ARREADY), .din(cmd_addr), .valid(ar_valid), .dout(ar_addr)
  );

  assign axi.AWVALID = aw_valid;
  assign axi.AWADDR  = aw_addr;
  assign axi.AWPROT  = PROT;
  assign axi.WVALID  = w_valid;
  assign axi.WDATA   = w_data;
  assign axi.WSTRB   = w_strb;
  assign axi.ARVALID = ar_valid;
  assign axi.ARADDR  = ar_addr;
  assign axi.ARPROT  = PROT;
  assign axi.BREADY  = (state == ST_WRESP);
  assign axi.RREADY  = (state == ST_RDATA);

  // A channel counts as done once its VALID has dropped or it handshakes this cycle.
  assign aw_ok = !aw_valid || axi.AWREADY;
  assign w_ok  = !w_valid  || axi.WREADY;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;

  // Cycle k after acceptance holds cnt = k-1, so RSP is entered TIMEOUT_CYC cycles after acceptance.
  always_ff @(posedge ACLK) begin
    if (!ARESETn || accept) cnt <= '0;
    else if (busy && cnt != CNT_LAST) cnt <= cnt + 1'b1;
  end

  assign timeout_hit = busy && (cnt == CNT_LAST) && !done_now;
  assign rsp_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = cmd_write ? ST_WADDR : ST_RADDR;
      ST_WADDR: if (aw_ok && w_ok) state_next = ST_WRESP;
      ST_WRESP: if (axi.BVALID) state_next = ST_RSP;
      ST_RADDR: if (ar_valid && axi.ARREADY) state_next = ST_RDATA;
      ST_RDATA: if (axi.RVALID) state_next = ST_RSP;
      ST_RSP:   if (rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (timeout_hit) state_next = ST_RSP;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else if (timeout_hit) begin
      rdata_q <= '0;
      resp_q  <= RESP_SLVERR;
    end else if ((state == ST_WRESP) && axi.BVALID) begin
      rdata_q <= '0;
      resp_q  <= axi.BRESP;
    end else if ((state == ST_RDATA) && axi.RVALID) begin
      rdata_q <= axi.RDATA;
      resp_q  <= axi.RRESP;
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  always_ff @(posedge ACLK) begin
    if (!ARESETn)         timeout_q <= 1'b0;
    else if (timeout_hit) timeout_q <= 1'b1;
    else if (done_now)    timeout_q <= 1'b0;
  end
`endif

  assign rsp_valid = (state == ST_RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

endmodule
